// File: rtl/axil_regbank.sv
// AXI4-Lite slave register bank: RW control registers below, read-only status
// registers at the top indices, byte strobes, SLVERR decode, per-index pulses.
module axil_regbank #(
  parameter int                      C_DATA_WIDTH = 32,
  parameter int                      C_ADDR_WIDTH = 6,
  parameter int                      C_NUM_REGS   = 16,
  parameter int                      C_NUM_RO     = 4,
  parameter logic [C_DATA_WIDTH-1:0] C_RESET_VAL  = '0
) (
  input  logic                                         ACLK,
  input  logic                                         ARESETN,
  input  logic [C_ADDR_WIDTH-1:0]                      AWADDR,
  input  logic [2:0]                                   AWPROT,
  input  logic                                         AWVALID,
  output logic                                         AWREADY,
  input  logic [C_DATA_WIDTH-1:0]                      WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]                    WSTRB,
  input  logic                                         WVALID,
  output logic                                         WREADY,
  output logic [1:0]                                   BRESP,
  output logic                                         BVALID,
  input  logic                                         BREADY,
  input  logic [C_ADDR_WIDTH-1:0]                      ARADDR,
  input  logic [2:0]                                   ARPROT,
  input  logic                                         ARVALID,
  output logic                                         ARREADY,
  output logic [C_DATA_WIDTH-1:0]                      RDATA,
  output logic [1:0]                                   RRESP,
  output logic                                         RVALID,
  input  logic                                         RREADY,
  output logic [(C_NUM_REGS-C_NUM_RO)*C_DATA_WIDTH-1:0] ctrl_o,
  input  logic [C_NUM_RO*C_DATA_WIDTH-1:0]             status_i,
  output logic [C_NUM_REGS-1:0]                        wr_pulse_o,
  output logic [C_NUM_REGS-1:0]                        rd_pulse_o
);

  localparam int NB   = C_DATA_WIDTH / 8;
  localparam int LSB  = $clog2(NB);
  localparam int IDXW = C_ADDR_WIDTH - LSB;
  localparam int NRW  = C_NUM_REGS - C_NUM_RO;

  // Handshake rule for every channel: a beat transfers on a rising edge where
  // VALID and READY are both high. All READY/VALID outputs come straight from
  // flops, so no input reaches a READY combinationally.
  logic [C_DATA_WIDTH-1:0] regs_q [NRW];
  logic                    ready_en_q;
  logic                    aw_held_q, w_held_q, bvalid_q;
  logic [IDXW-1:0]         aw_idx_q;
  logic [C_DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]           wstrb_q;
  logic [1:0]              bresp_q;
  logic [C_NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic                    rvalid_q;
  logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]              rresp_q;
  logic [C_NUM_REGS-1:0]   rd_pulse_q, rd_pulse_d;

  logic aw_hs, w_hs, ar_hs, commit, w_err, r_err;
  int   w_idx, r_idx;
  logic unused_ok;

  assign unused_ok = ^{AWPROT, ARPROT, AWADDR[LSB-1:0], ARADDR[LSB-1:0]};

  assign AWREADY = ready_en_q & ~aw_held_q & ~bvalid_q;
  assign WREADY  = ready_en_q & ~w_held_q & ~bvalid_q;
  assign ARREADY = ready_en_q & ~rvalid_q;
  assign aw_hs   = AWVALID & AWREADY;
  assign w_hs    = WVALID & WREADY;
  assign ar_hs   = ARVALID & ARREADY;
  assign commit  = aw_held_q & w_held_q & ~bvalid_q;

  assign BVALID     = bvalid_q;
  assign BRESP      = bresp_q;
  assign RVALID     = rvalid_q;
  assign RDATA      = rdata_q;
  assign RRESP      = rresp_q;
  assign wr_pulse_o = wr_pulse_q;
  assign rd_pulse_o = rd_pulse_q;

  for (genvar g = 0; g < NRW; g++) begin : g_ctrl
    assign ctrl_o[g*C_DATA_WIDTH +: C_DATA_WIDTH] = regs_q[g];
  end

  always_comb begin
    w_idx      = int'(aw_idx_q);
    r_idx      = int'(ARADDR[C_ADDR_WIDTH-1:LSB]);
    w_err      = (w_idx >= NRW);
    r_err      = (r_idx >= C_NUM_REGS);
    rdata_d    = '0;
    wr_pulse_d = '0;
    rd_pulse_d = '0;
    for (int i = 0; i < NRW; i++)
      if (r_idx == i) rdata_d = regs_q[i];
    for (int k = 0; k < C_NUM_RO; k++)
      if (r_idx == NRW + k) rdata_d = status_i[k*C_DATA_WIDTH +: C_DATA_WIDTH];
    for (int i = 0; i < C_NUM_REGS; i++) begin
      wr_pulse_d[i] = commit & ~w_err & (w_idx == i);
      rd_pulse_d[i] = ar_hs & (r_idx == i);
    end
  end

  // Write address/data holding, commit and response.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      wr_pulse_q <= '0;
    end else begin
      ready_en_q <= 1'b1;
      wr_pulse_q <= wr_pulse_d;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= AWADDR[C_ADDR_WIDTH-1:LSB];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= WDATA;
        wstrb_q  <= WSTRB;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= w_err ? 2'b10 : 2'b00;
      end else if (bvalid_q && BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NRW; i++) regs_q[i] <= C_RESET_VAL;
    end else if (commit) begin
      for (int i = 0; i < NRW; i++)
        if (w_idx == i)
          for (int b = 0; b < NB; b++)
            if (wstrb_q[b]) regs_q[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
    end
  end

  // Read path samples the pre-commit register value on a coincident write.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      rd_pulse_q <= '0;
    end else begin
      rd_pulse_q <= rd_pulse_d;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
        rresp_q  <= r_err ? 2'b10 : 2'b00;
      end else if (rvalid_q && RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axil_regbank.sv
// Bench for axil_regbank: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic checked against a register-array model.
`timescale 1ns/1ps
module tb_axil_regbank;
  localparam int DW  = 32;
  localparam int AW  = 7;
  localparam int NR  = 16;
  localparam int NRO = 4;
  localparam int NRW = NR - NRO;
  localparam logic [DW-1:0] RST = 32'hC0DE_0000;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESETN;
  always #5 ACLK = ~ACLK;

  logic [AW-1:0]       AWADDR, ARADDR;
  logic [2:0]          AWPROT, ARPROT;
  logic                AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic                ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0]       WDATA, RDATA;
  logic [DW/8-1:0]     WSTRB;
  logic [1:0]          BRESP, RRESP;
  logic [NRW*DW-1:0]   ctrl_o;
  logic [NRO*DW-1:0]   status_i;
  logic [NR-1:0]       wr_pulse_o, rd_pulse_o;

  axil_regbank #(
    .C_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW), .C_NUM_REGS(NR),
    .C_NUM_RO(NRO), .C_RESET_VAL(RST)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .ctrl_o(ctrl_o), .status_i(status_i),
    .wr_pulse_o(wr_pulse_o), .rd_pulse_o(rd_pulse_o)
  );

  // ---------------- scoreboard / model ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [DW-1:0] model_regs [NRW];
  logic [DW-1:0] exp_q [$];
  int wr_cnt [NR] = '{default: 0};

  always @(negedge ACLK)
    for (int i = 0; i < NR; i++) if (wr_pulse_o[i] === 1'b1) wr_cnt[i]++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_ctrl(input string name);
    logic [NRW*DW-1:0] e;
    for (int i = 0; i < NRW; i++) e[i*DW +: DW] = model_regs[i];
    n_total++;
    if (ctrl_o !== e) $display("FAIL %s: got %0h expected %0h", name, ctrl_o, e);
    else n_pass++;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NRW; i++) model_regs[i] = RST;
  endfunction

  function automatic logic [1:0] model_write(input int idx, input logic [DW-1:0] d,
                                             input logic [3:0] s);
    if (idx >= NRW) return 2'b10;
    for (int b = 0; b < 4; b++) if (s[b]) model_regs[idx][b*8 +: 8] = d[b*8 +: 8];
    return 2'b00;
  endfunction

  function automatic logic [1:0] model_read(input int idx, output logic [DW-1:0] d);
    d = '0;
    if (idx < NRW) d = model_regs[idx];
    else if (idx < NR) d = status_i[(idx-NRW)*DW +: DW];
    else return 2'b10;
    return 2'b00;
  endfunction

  function automatic int total_wr();
    int s = 0;
    for (int i = 0; i < NR; i++) s += wr_cnt[i];
    return s;
  endfunction

  // ---------------- driver tasks (enter and leave at a negedge) ----------------
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] strb, output logic [1:0] resp,
                          output logic [NR-1:0] pulse);
    logic aw_done = 1'b0, w_done = 1'b0;
    int n = 0;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      if (AWVALID && AWREADY) aw_done = 1'b1;
      if (WVALID && WREADY) w_done = 1'b1;
      @(negedge ACLK); n++;
      if (aw_done) AWVALID = 1'b0;
      if (w_done) WVALID = 1'b0;
    end
    n = 0;
    while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
    if (!BVALID) begin
      check("write_timeout", 64'd0, 64'd1);
      AWVALID = 1'b0; WVALID = 1'b0; resp = 2'b11; pulse = '0;
    end else begin
      resp = BRESP; pulse = wr_pulse_o;
      @(negedge ACLK);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int rdelay,
                         output logic [DW-1:0] data, output logic [1:0] resp,
                         output logic [NR-1:0] pulse);
    int n = 0;
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b0;
    while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    ARVALID = 1'b0;
    pulse = rd_pulse_o;
    repeat (rdelay) @(negedge ACLK);
    if (!RVALID) begin
      check("read_timeout", 64'd0, 64'd1);
      data = 'x; resp = 2'b11;
    end else begin
      data = RDATA; resp = RRESP;
      RREADY = 1'b1;
      @(negedge ACLK);
      RREADY = 1'b0;
    end
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    strb;
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_resp;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    logic [1:0] resp;
    logic [DW-1:0] data, ed;
    logic [NR-1:0] pulse;
    logic [31:0] one;
    int idx, c0, s0, bad;

    vecs[0]  = '{1'b1, 7'h00, 32'h1,        4'hF, 32'h0,        2'b00};
    vecs[1]  = '{1'b1, 7'h04, 32'h2,        4'hF, 32'h0,        2'b00};
    vecs[2]  = '{1'b1, 7'h08, 32'h3,        4'hF, 32'h0,        2'b00};
    vecs[3]  = '{1'b1, 7'h0C, 32'h4,        4'hF, 32'h0,        2'b00};
    vecs[4]  = '{1'b0, 7'h00, 32'h0,        4'h0, 32'h1,        2'b00};
    vecs[5]  = '{1'b0, 7'h04, 32'h0,        4'h0, 32'h2,        2'b00};
    vecs[6]  = '{1'b0, 7'h08, 32'h0,        4'h0, 32'h3,        2'b00};
    vecs[7]  = '{1'b0, 7'h0C, 32'h0,        4'h0, 32'h4,        2'b00};
    vecs[8]  = '{1'b1, 7'h00, 32'hAABBCCDD, 4'hF, 32'h0,        2'b00};
    vecs[9]  = '{1'b1, 7'h00, 32'h11223344, 4'h5, 32'h0,        2'b00};
    vecs[10] = '{1'b0, 7'h00, 32'h0,        4'h0, 32'hAA22CC44, 2'b00};
    vecs[11] = '{1'b0, 7'h30, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
    vecs[12] = '{1'b1, 7'h30, 32'h12345678, 4'hF, 32'h0,        2'b10};
    vecs[13] = '{1'b0, 7'h30, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
    vecs[14] = '{1'b0, 7'h40, 32'h0,        4'h0, 32'h0,        2'b10};
    vecs[15] = '{1'b1, 7'h40, 32'h99999999, 4'hF, 32'h0,        2'b10};
    vecs[16] = '{1'b1, 7'h08, 32'hFFFFFFFF, 4'h0, 32'h0,        2'b00};
    vecs[17] = '{1'b0, 7'h08, 32'h0,        4'h0, 32'h3,        2'b00};
    vecs[18] = '{1'b0, 7'h3C, 32'h0,        4'h0, 32'h0BADF00D, 2'b00};
    vecs[19] = '{1'b0, 7'h28, 32'h0,        4'h0, 32'hC0DE0000, 2'b00};
    vecs[20] = '{1'b1, 7'h2C, 32'h5555AAAA, 4'hC, 32'h0,        2'b00};
    vecs[21] = '{1'b0, 7'h2C, 32'h0,        4'h0, 32'h55550000, 2'b00};
    vecs[22] = '{1'b0, 7'h7C, 32'h0,        4'h0, 32'h0,        2'b10};

    AWADDR = '0; ARADDR = '0; AWPROT = 3'b0; ARPROT = 3'b0;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0; BREADY = 1'b0; RREADY = 1'b0;
    WDATA = '0; WSTRB = '0;
    status_i = {32'h0BADF00D, 32'h33333333, 32'h22222222, 32'hDEADBEEF};
    model_reset();

    // ---------------- reset state ----------------
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    check("reset_ready_valid", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b0);
    check("reset_resp_data", {BRESP, RRESP, RDATA}, 64'd0);
    check("reset_pulses", {wr_pulse_o, rd_pulse_o}, 64'd0);
    check_ctrl("reset_ctrl");
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("ready_after_release", {AWREADY, WREADY, ARREADY}, 3'b111);

    // ---------------- directed vector table ----------------
    for (int i = 0; i < NV; i++) begin
      idx = int'(vecs[i].addr >> 2);
      one = 32'd1 << idx;
      if (vecs[i].wr) begin
        s0 = total_wr();
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, pulse);
        void'(model_write(idx, vecs[i].data, vecs[i].strb));
        check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
        check($sformatf("vec%0d_wr_pulse", i), pulse,
              (vecs[i].exp_resp == 2'b00) ? one[NR-1:0] : '0);
        check($sformatf("vec%0d_wr_pulse_count", i), total_wr() - s0,
              (vecs[i].exp_resp == 2'b00) ? 1 : 0);
      end else begin
        do_read(vecs[i].addr, i % 3, data, resp, pulse);
        check($sformatf("vec%0d_rdata", i), data, vecs[i].exp_data);
        check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
        check($sformatf("vec%0d_rd_pulse", i), pulse, (idx < NR) ? one[NR-1:0] : '0);
      end
    end
    check_ctrl("table_ctrl");

    // ---------------- W three cycles before AW, B stalled ----------------
    c0 = wr_cnt[2];
    WDATA = 32'h77; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
    check("A_wready_idle", WREADY, 1'b1);
    @(negedge ACLK);
    WVALID = 1'b0;
    check("A_wready_low_held", WREADY, 1'b0);
    repeat (2) @(negedge ACLK);
    check("A_no_early_bvalid", BVALID, 1'b0);
    AWADDR = 7'h08; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    @(negedge ACLK);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (!(BVALID && !AWREADY && !WREADY && BRESP == 2'b00)) bad++;
      @(negedge ACLK);
    end
    check("A_stall_hold", bad, 0);
    BREADY = 1'b1;
    @(negedge ACLK);
    check("A_after_b", {BVALID, AWREADY, WREADY}, 3'b011);
    check("A_single_pulse", wr_cnt[2] - c0, 1);
    void'(model_write(2, 32'h77, 4'hF));
    do_read(7'h08, 0, data, resp, pulse);
    check("A_readback", data, 32'h77);

    // ---------------- commit and AR on the same edge ----------------
    AWADDR = 7'h04; WDATA = 32'h5; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b0;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 7'h04; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    check("B_both_valid", {RVALID, BVALID}, 2'b11);
    check("B_same_edge_rdata", RDATA, 32'h2);
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    void'(model_write(1, 32'h5, 4'hF));
    do_read(7'h04, 0, data, resp, pulse);
    check("B_next_read", data, 32'h5);

    // ---------------- reset during a half-complete write ----------------
    AWADDR = 7'h0C; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    @(negedge ACLK);
    #2 ARESETN = 1'b0;
    #1;
    check("C_reset_outputs", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b0);
    model_reset();
    check_ctrl("C_reset_ctrl");
    bad = 0;
    repeat (3) begin @(negedge ACLK); if (BVALID) bad++; end
    ARESETN = 1'b1;
    repeat (3) begin @(negedge ACLK); if (BVALID) bad++; end
    check("C_no_bvalid", bad, 0);
    check("C_ready_after_release", {AWREADY, WREADY, ARREADY}, 3'b111);
    do_write(7'h0C, 32'hCAFEF00D, 4'hF, resp, pulse);
    void'(model_write(3, 32'hCAFEF00D, 4'hF));
    check("C_fresh_bresp", resp, 2'b00);
    do_read(7'h0C, 1, data, resp, pulse);
    check("C_fresh_read", data, 32'hCAFEF00D);
    do_read(7'h00, 0, data, resp, pulse);
    check("C_reg0_reset_val", data, RST);

    // ---------------- randomized traffic vs model ----------------
    for (int i = 0; i < 80; i++) begin
      idx = int'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        WSTRB = 4'($urandom_range(0, 15));
        ed = data;
        do_write(7'(idx * 4), ed, WSTRB, resp, pulse);
        check($sformatf("rnd%0d_bresp_idx%0d", i, idx), resp, model_write(idx, ed, WSTRB));
      end else begin
        if ($urandom_range(0, 3) == 0) status_i[$urandom_range(0, NRO-1)*DW +: DW] = $urandom;
        resp = model_read(idx, ed);
        exp_q.push_back(ed);
        do_read(7'(idx * 4), int'($urandom_range(0, 2)), data, pulse[1:0], pulse);
        check($sformatf("rnd%0d_rdata_idx%0d", i, idx), data, exp_q.pop_front());
        check($sformatf("rnd%0d_rresp_idx%0d", i, idx), RRESP, resp);
      end
    end
    check_ctrl("final_ctrl");
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
